fifo_ctrl_non2n: RTL and testbench

FIFO_CTRL_NON2N -- requirements
Module: fifo_ctrl_non2n

---
 rtl/fifo_ctrl_non2n.sv | 124 ++++++++++++
 tb/tb_fifo_ctrl_non2n.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_non2n.sv
// Single-clock FIFO controller whose pointers wrap inside a non-power-of-two address window
// centred in the memory, with two-way round-robin write arbitration and sticky underflow detect.
module fifo_ctrl_non2n #(
  parameter int FIFO_DEPTH = 520,
  parameter int PTR_WIDTH  = 10,
  parameter int MEM_SIZE   = 1 << PTR_WIDTH,
  parameter int START_ADDR = MEM_SIZE/2 - FIFO_DEPTH/2,
  parameter int END_ADDR   = MEM_SIZE/2 + FIFO_DEPTH/2 - 1,
  parameter int AFULL_LVL  = FIFO_DEPTH - 8
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 r_en,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 mem_we,
  output logic                 mem_wsel,
  output logic [PTR_WIDTH-1:0] mem_waddr,
  output logic                 mem_re,
  output logic [PTR_WIDTH-1:0] mem_raddr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   count,
  output logic                 udf_err
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] START_P = PTR_WIDTH'(START_ADDR);
  localparam logic [PTR_WIDTH-1:0] END_P   = PTR_WIDTH'(END_ADDR);
  localparam logic [PTR_WIDTH-1:0] P_ONE   = PTR_WIDTH'(1);
  localparam logic [CW-1:0]        C_ONE   = CW'(1);
  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        AFULL_C = CW'(AFULL_LVL);

  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 afull_q, afull_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 udf_q, udf_d;
  logic                 acc_w, acc_r;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == END_P) ? START_P : p + P_ONE;
  endfunction

  // last_gnt_q=1 means req1 was served last, so req0 wins the next contention.
  assign gnt0 = wrst_n & ~full_q & req0 & (~req1 | last_gnt_q);
  assign gnt1 = wrst_n & ~full_q & req1 & (~req0 | ~last_gnt_q);

  assign acc_w = gnt0 | gnt1;
  assign acc_r = wrst_n & r_en & ~empty_q;

  assign mem_we    = acc_w;
  assign mem_wsel  = gnt1;
  assign mem_waddr = wptr_q;
  assign mem_re    = acc_r;
  assign mem_raddr = rptr_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    last_gnt_d = last_gnt_q;
    udf_d      = udf_q;

    if (acc_w) begin
      wptr_d     = ptr_inc(wptr_q);
      last_gnt_d = gnt1;
    end
    if (acc_r) begin
      rptr_d = ptr_inc(rptr_q);
    end

    unique case ({acc_w, acc_r})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase

    // A read on an empty FIFO is only an error when no write lands in the same cycle.
    if (wrst_n && r_en && empty_q && !acc_w) begin
      udf_d = 1'b1;
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    afull_d = (count_d >= AFULL_C);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q     <= START_P;
      rptr_q     <= START_P;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      last_gnt_q <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      last_gnt_q <= last_gnt_d;
      udf_q      <= udf_d;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign udf_err     = udf_q;

endmodule

// File: tb/tb_fifo_ctrl_non2n.sv
// Randomized + directed bench for fifo_ctrl_non2n; a queue-based reference model feeds a
// scoreboard that a negedge monitor drains whenever the DUT strobes or a cycle completes.
module tb_fifo_ctrl_non2n;

  localparam int PW    = 10;
  localparam int DEPTH = 520;
  localparam int START = 252;
  localparam int AFULL = DEPTH - 8;

  logic          wclk;
  logic          wrst_n;
  logic          req0, req1, r_en;
  logic          gnt0, gnt1, mem_we, mem_wsel, mem_re;
  logic [PW-1:0] mem_waddr, mem_raddr;
  logic          full, empty, almost_full, udf_err;
  logic [PW:0]   count;

  fifo_ctrl_non2n dut (
    .wclk(wclk), .wrst_n(wrst_n), .req0(req0), .req1(req1), .r_en(r_en),
    .gnt0(gnt0), .gnt1(gnt1), .mem_we(mem_we), .mem_wsel(mem_wsel),
    .mem_waddr(mem_waddr), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .udf_err(udf_err)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    int cnt;
    bit full, empty, af, udf, g0, g1, we, re;
    int waddr, raddr;
  } st_t;
  typedef struct { int sel; int addr; } wr_t;

  st_t sq[$];
  wr_t wq[$];
  int  rq[$];

  int  errors = 0;
  int  checks = 0;

  // reference model: the FIFO contents are the addresses written, oldest first
  int  m_q[$];
  int  m_nw, m_nr, m_last;
  bit  m_udf;

  task automatic check(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  task automatic drive(input bit r0, input bit r1, input bit re, input bit rst);
    st_t s;
    wr_t w;
    int  g, sz;
    bit  wr, rd;
    @(posedge wclk);
    #1;
    wrst_n = !rst;
    req0 = r0;
    req1 = r1;
    r_en = re;
    if (rst) begin
      m_q.delete();
      m_nw = 0; m_nr = 0; m_last = 0; m_udf = 0;
    end
    sz = m_q.size();
    g = -1;
    if (!rst && sz < DEPTH) begin
      if (r0 && r1)  g = (m_last == 0) ? 1 : 0;
      else if (r0)   g = 0;
      else if (r1)   g = 1;
    end
    wr = (g >= 0);
    rd = !rst && re && (sz > 0);
    s.cnt = sz; s.full = (sz == DEPTH); s.empty = (sz == 0); s.af = (sz >= AFULL);
    s.udf = m_udf; s.g0 = (g == 0); s.g1 = (g == 1); s.we = wr; s.re = rd;
    s.waddr = START + (m_nw % DEPTH);
    s.raddr = (sz > 0) ? m_q[0] : START + (m_nr % DEPTH);
    sq.push_back(s);
    if (wr) begin
      w.sel = g; w.addr = s.waddr;
      wq.push_back(w);
    end
    if (rd) rq.push_back(s.raddr);
    if (!rst && re && sz == 0 && !wr) m_udf = 1;
    if (rd) begin void'(m_q.pop_front()); m_nr++; end
    if (wr) begin m_q.push_back(s.waddr); m_nw++; m_last = g; end
    $display("cyc t=%0t rst=%0b req=%0b%0b r_en=%0b exp_cnt=%0d exp_we=%0b exp_re=%0b",
             $time, rst, r0, r1, re, sz, wr, rd);
  endtask

  st_t mon_s;
  wr_t mon_w;
  int  mon_r;

  initial begin
    forever begin
      @(negedge wclk);
      if (sq.size() > 0) begin
        mon_s = sq.pop_front();
        check("count",       int'(count),       mon_s.cnt);
        check("full",        int'(full),        int'(mon_s.full));
        check("empty",       int'(empty),       int'(mon_s.empty));
        check("almost_full", int'(almost_full), int'(mon_s.af));
        check("udf_err",     int'(udf_err),     int'(mon_s.udf));
        check("gnt0",        int'(gnt0),        int'(mon_s.g0));
        check("gnt1",        int'(gnt1),        int'(mon_s.g1));
        check("mem_we",      int'(mem_we),      int'(mon_s.we));
        check("mem_re",      int'(mem_re),      int'(mon_s.re));
        check("mem_waddr",   int'(mem_waddr),   mon_s.waddr);
        check("mem_raddr",   int'(mem_raddr),   mon_s.raddr);
      end
      if (mem_we) begin
        check("write_expected", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          mon_w = wq.pop_front();
          check("wr_wsel", int'(mem_wsel),  mon_w.sel);
          check("wr_addr", int'(mem_waddr), mon_w.addr);
        end
      end
      if (mem_re) begin
        check("read_expected", int'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          mon_r = rq.pop_front();
          check("rd_addr", int'(mem_raddr), mon_r);
        end
      end
    end
  end

  initial begin
    int wp, rp;
    bit a, b, c;
    wrst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; r_en = 1'b0;

    repeat (3) drive(1, 1, 1, 1);      // requests during reset must not strobe
    repeat (3) drive(0, 0, 0, 0);
    repeat (8) drive(1, 1, 0, 0);      // contention: gnt1 first, then alternating
    repeat (2) drive(0, 0, 0, 1);

    repeat (DEPTH) drive(1, 0, 0, 0);  // fill to the top of the window and wrap
    drive(0, 0, 0, 0);
    drive(1, 0, 1, 0);                 // full: read accepted, write blocked
    drive(0, 0, 0, 0);
    repeat (DEPTH - 1) drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);                 // empty: write accepted, read ignored, no underflow
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);                 // genuine underflow
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    repeat (300) drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 1, 1, 1);                 // reset pulse at count=300
    repeat (2) drive(0, 0, 0, 0);

    for (int p = 0; p < 8; p++) begin
      wp = $urandom_range(95, 20);
      rp = $urandom_range(90, 5);
      for (int i = 0; i < 400; i++) begin
        a = ($urandom % 100) < wp;
        b = ($urandom % 100) < wp;
        c = ($urandom % 100) < rp;
        drive(a, b, c, ($urandom % 500) == 0);
      end
    end

    repeat (2) drive(0, 0, 0, 0);
    @(negedge wclk);
    #1;
    check("status_drained", sq.size(), 0);
    check("writes_drained", wq.size(), 0);
    check("reads_drained",  rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
